// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_pkg
// Description : Shared types and constants for the MAC link test sequencer:
//               sequencer state encoding, completion-status values and
//               failure codes, plus a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_GT  = 3'd1,
        ST_WAIT_BLK = 3'd2,
        ST_WAIT_CS  = 3'd3,
        ST_SETTLE   = 3'd4,
        ST_REPORT   = 3'd5,
        ST_RESTART  = 3'd6,
        ST_DONE     = 3'd7
    } seq_state_t;

    // completion_status values reported by the MAC example
    localparam logic [4:0] CS_IDLE      = 5'h00;
    localparam logic [4:0] CS_PASS      = 5'h01;
    localparam logic [4:0] CS_RESET     = 5'h1F;

    // Sequencer-generated failure codes (outside the MAC's own code range)
    localparam logic [4:0] FC_GT_TO     = 5'd16;
    localparam logic [4:0] FC_BLK_TO    = 5'd17;
    localparam logic [4:0] FC_CS_TO     = 5'd18;
    localparam logic [4:0] FC_LOCK_LOST = 5'd19;

    // 4-bit increment that sticks at 15
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_seq_status_sync.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_status_sync
// Description : Reset synchronizer (async assert, sync release), 2-flop
//               synchronizers for the MAC lock/start inputs, and a stability
//               filter that only accepts completion_status after it has been
//               seen unchanged for STABLE_CYCLES consecutive samples.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_status_sync #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       dclk,
    input  logic       sys_reset,
    input  logic       rx_gt_locked_in,
    input  logic       rx_block_lock_in,
    input  logic [4:0] completion_status_in,
    input  logic       start,
    output logic       rst_n_sync,
    output logic       gt_locked,
    output logic       block_lock,
    output logic       start_sync,
    output logic [4:0] cs
);

    localparam int             c_CW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_STABLE = c_CW'(STABLE_CYCLES);
    localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

    logic [1:0]      r_rst_sync;
    logic [1:0]      r_gt_s;
    logic [1:0]      r_blk_s;
    logic [1:0]      r_start_s;
    logic [4:0]      r_cs_s1;
    logic [4:0]      r_cs_s2;
    logic [4:0]      r_cs_last;
    logic [c_CW-1:0] r_cnt;
    logic [4:0]      r_cs;
    logic            w_rst_n;
    logic            w_same;
    logic [c_CW-1:0] w_cnt_nx;

    // Reset release is re-timed to dclk; assertion stays asynchronous
    always_ff @(posedge dclk or negedge sys_reset) begin
        if (!sys_reset) r_rst_sync <= 2'b00;
        else            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // Run length of the current synchronized status value, capped at the threshold
    assign w_same   = (r_cs_s2 == r_cs_last);
    assign w_cnt_nx = !w_same ? c_ONE : ((r_cnt == c_STABLE) ? r_cnt : r_cnt + c_ONE);

    // Two-flop synchronizers and the completion_status stability filter
    always_ff @(posedge dclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_gt_s    <= 2'b00;
            r_blk_s   <= 2'b00;
            r_start_s <= 2'b00;
            r_cs_s1   <= 5'd0;
            r_cs_s2   <= 5'd0;
            r_cs_last <= 5'd0;
            r_cnt     <= '0;
            r_cs      <= 5'd0;
        end else begin
            r_gt_s    <= {r_gt_s[0], rx_gt_locked_in};
            r_blk_s   <= {r_blk_s[0], rx_block_lock_in};
            r_start_s <= {r_start_s[0], start};
            r_cs_s1   <= completion_status_in;
            r_cs_s2   <= r_cs_s1;
            r_cs_last <= r_cs_s2;
            r_cnt     <= w_cnt_nx;
            if (w_cnt_nx == c_STABLE) r_cs <= r_cs_s2;
        end
    end

    assign rst_n_sync = w_rst_n;
    assign gt_locked  = r_gt_s[1];
    assign block_lock = r_blk_s[1];
    assign start_sync = r_start_s[1];
    assign cs         = r_cs;

endmodule
`default_nettype wire

// File: rtl/mac_link_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mac_link_test_sequencer
// Description : Drives the 25GE QSFP MAC loopback example through NUM_RUNS
//               test runs: waits for GT and block lock, waits for a
//               completion_status verdict, lets it settle, scores the run and
//               pulses restart_tx_rx between runs. Reports an overall verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_link_test_sequencer
    import mac_seq_pkg::*;
#(
    parameter int LOCK_TO_BIT    = 20,
    parameter int STATUS_TO_BIT  = 24,
    parameter int SETTLE_CYCLES  = 10000,
    parameter int RESTART_CYCLES = 10,
    parameter int NUM_RUNS       = 2,
    parameter int STABLE_CYCLES  = 4
) (
    input  logic       dclk,
    input  logic       sys_reset,
    input  logic       rx_gt_locked_in,
    input  logic       rx_block_lock_in,
    input  logic [4:0] completion_status_in,
    input  logic       start,
    output logic       restart_tx_rx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_code,
    output logic [3:0] run_index,
    output logic [3:0] pass_count,
    output logic [3:0] fail_count
);

    localparam int c_TW      = ((LOCK_TO_BIT > STATUS_TO_BIT) ? LOCK_TO_BIT : STATUS_TO_BIT) + 1;
    localparam int c_DLY_MAX = (SETTLE_CYCLES > RESTART_CYCLES) ? SETTLE_CYCLES : RESTART_CYCLES;
    localparam int c_DW      = $clog2(c_DLY_MAX + 1);

    localparam logic [c_TW-1:0] c_TMO_ONE      = c_TW'(1);
    localparam logic [c_DW-1:0] c_DLY_ONE      = c_DW'(1);
    localparam logic [c_DW-1:0] c_SETTLE_LAST  = c_DW'(SETTLE_CYCLES - 1);
    localparam logic [c_DW-1:0] c_RESTART_LAST = c_DW'(RESTART_CYCLES - 1);
    localparam logic [3:0]      c_LAST_RUN     = 4'(NUM_RUNS - 1);

    logic       w_rst_n;
    logic       w_gt_locked;
    logic       w_block_lock;
    logic       w_start_s;
    logic [4:0] w_cs;

    seq_state_t      r_state;
    logic [c_TW-1:0] r_tmo;
    logic [c_DW-1:0] r_dly;
    logic [4:0]      r_run_code;
    logic            r_restart;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [4:0]      r_fail_code;
    logic [3:0]      r_run_idx;
    logic [3:0]      r_pass_cnt;
    logic [3:0]      r_fail_cnt;
    logic            r_start_d;
    logic            r_gt_d;
    logic            r_blk_d;

    logic            w_start_rise;
    logic            w_lock_lost;
    logic            w_cs_valid;
    logic            w_run_failed;
    logic [3:0]      w_pass_cnt_nx;
    logic [3:0]      w_fail_cnt_nx;
    logic [4:0]      w_fail_code_nx;

    mac_seq_status_sync #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_status_sync (
        .dclk                 (dclk),
        .sys_reset            (sys_reset),
        .rx_gt_locked_in      (rx_gt_locked_in),
        .rx_block_lock_in     (rx_block_lock_in),
        .completion_status_in (completion_status_in),
        .start                (start),
        .rst_n_sync           (w_rst_n),
        .gt_locked            (w_gt_locked),
        .block_lock           (w_block_lock),
        .start_sync           (w_start_s),
        .cs                   (w_cs)
    );

    // Previous-cycle copies for start-rise and lock-fall detection
    always_ff @(posedge dclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_start_d <= 1'b0;
            r_gt_d    <= 1'b0;
            r_blk_d   <= 1'b0;
        end else begin
            r_start_d <= w_start_s;
            r_gt_d    <= w_gt_locked;
            r_blk_d   <= w_block_lock;
        end
    end

    assign w_start_rise = w_start_s & ~r_start_d;
    assign w_lock_lost  = (r_gt_d & ~w_gt_locked) | (r_blk_d & ~w_block_lock);
    assign w_cs_valid   = (w_cs != CS_IDLE) && (w_cs != CS_RESET);

    // Scoring of the run being reported; the first failing code is kept
    assign w_run_failed   = (r_run_code != CS_PASS);
    assign w_pass_cnt_nx  = w_run_failed ? r_pass_cnt : sat_inc4(r_pass_cnt);
    assign w_fail_cnt_nx  = w_run_failed ? sat_inc4(r_fail_cnt) : r_fail_cnt;
    assign w_fail_code_nx = (w_run_failed && (r_fail_code == 5'd0)) ? r_run_code : r_fail_code;

    // Sequencer: lock waits, status wait/settle, scoring and restart pulse
    always_ff @(posedge dclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_tmo       <= '0;
            r_dly       <= '0;
            r_run_code  <= 5'd0;
            r_restart   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= 5'd0;
            r_run_idx   <= 4'd0;
            r_pass_cnt  <= 4'd0;
            r_fail_cnt  <= 4'd0;
        end else begin
            // Both counters restart from zero whenever a state is (re)entered
            r_tmo <= '0;
            r_dly <= '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_rise) begin
                        r_state     <= ST_WAIT_GT;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_code <= 5'd0;
                        r_run_idx   <= 4'd0;
                        r_pass_cnt  <= 4'd0;
                        r_fail_cnt  <= 4'd0;
                    end
                end
                ST_WAIT_GT: begin
                    if (w_gt_locked) begin
                        r_state <= ST_WAIT_BLK;
                    end else if (r_tmo[LOCK_TO_BIT]) begin
                        r_fail_code <= FC_GT_TO;
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_ONE;
                    end
                end
                ST_WAIT_BLK: begin
                    if (w_block_lock) begin
                        r_state <= ST_WAIT_CS;
                    end else if (r_tmo[LOCK_TO_BIT]) begin
                        r_fail_code <= FC_BLK_TO;
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_pass      <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_ONE;
                    end
                end
                ST_WAIT_CS: begin
                    if (w_lock_lost) begin
                        r_run_code <= FC_LOCK_LOST;
                        r_state    <= ST_REPORT;
                    end else if (w_cs_valid) begin
                        r_state <= ST_SETTLE;
                    end else if (r_tmo[STATUS_TO_BIT]) begin
                        r_run_code <= FC_CS_TO;
                        r_state    <= ST_REPORT;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_ONE;
                    end
                end
                ST_SETTLE: begin
                    if (w_lock_lost) begin
                        r_run_code <= FC_LOCK_LOST;
                        r_state    <= ST_REPORT;
                    end else if (r_dly == c_SETTLE_LAST) begin
                        r_run_code <= w_cs;
                        r_state    <= ST_REPORT;
                    end else begin
                        r_dly <= r_dly + c_DLY_ONE;
                    end
                end
                ST_REPORT: begin
                    r_pass_cnt  <= w_pass_cnt_nx;
                    r_fail_cnt  <= w_fail_cnt_nx;
                    r_fail_code <= w_fail_code_nx;
                    if (r_run_idx == c_LAST_RUN) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fail_cnt_nx == 4'd0) && (w_fail_code_nx == 5'd0);
                    end else begin
                        r_run_idx <= sat_inc4(r_run_idx);
                        r_restart <= 1'b1;
                        r_state   <= ST_RESTART;
                    end
                end
                ST_RESTART: begin
                    if (w_lock_lost) begin
                        r_restart  <= 1'b0;
                        r_run_code <= FC_LOCK_LOST;
                        r_state    <= ST_REPORT;
                    end else if (r_dly == c_RESTART_LAST) begin
                        r_restart <= 1'b0;
                        r_state   <= ST_WAIT_CS;
                    end else begin
                        r_dly <= r_dly + c_DLY_ONE;
                    end
                end
                default: begin
                    r_restart <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign restart_tx_rx = r_restart;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail_code     = r_fail_code;
    assign run_index     = r_run_idx;
    assign pass_count    = r_pass_cnt;
    assign fail_count    = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_link_test_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_link_test_sequencer
// Description : Self-checking bench for mac_link_test_sequencer. Scenarios
//               play the MAC example's side of the handshake and compare the
//               final verdict with per-run outcomes scored by a simple model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_link_test_sequencer;

    localparam int c_LOCK_TO_BIT   = 8;
    localparam int c_STATUS_TO_BIT = 11;
    localparam int c_SETTLE        = 64;
    localparam int c_RESTART       = 10;
    localparam int c_NUM_RUNS      = 2;
    localparam int c_STABLE        = 4;

    logic       dclk = 1'b0;
    logic       sys_reset = 1'b0;
    logic       rx_gt_locked_in = 1'b0;
    logic       rx_block_lock_in = 1'b0;
    logic [4:0] completion_status_in = 5'h1F;
    logic       start = 1'b0;
    logic       restart_tx_rx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_code;
    logic [3:0] run_index;
    logic [3:0] pass_count;
    logic [3:0] fail_count;

    int n_checks = 0;
    int n_errors = 0;
    int widths[$];
    int cur_w = 0;

    always #5 dclk = ~dclk;

    mac_link_test_sequencer #(
        .LOCK_TO_BIT    (c_LOCK_TO_BIT),
        .STATUS_TO_BIT  (c_STATUS_TO_BIT),
        .SETTLE_CYCLES  (c_SETTLE),
        .RESTART_CYCLES (c_RESTART),
        .NUM_RUNS       (c_NUM_RUNS),
        .STABLE_CYCLES  (c_STABLE)
    ) dut (
        .dclk                 (dclk),
        .sys_reset            (sys_reset),
        .rx_gt_locked_in      (rx_gt_locked_in),
        .rx_block_lock_in     (rx_block_lock_in),
        .completion_status_in (completion_status_in),
        .start                (start),
        .restart_tx_rx        (restart_tx_rx),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .fail_code            (fail_code),
        .run_index            (run_index),
        .pass_count           (pass_count),
        .fail_count           (fail_count)
    );

    // Records the width of every restart_tx_rx pulse, sampled mid-cycle
    always @(negedge dclk) begin
        if (restart_tx_rx === 1'b1) cur_w++;
        else if (cur_w != 0) begin
            widths.push_back(cur_w);
            cur_w = 0;
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    // Bounded wait for restart_tx_rx (sel=0) or done (sel=1) to reach a level
    task automatic wait_level(input logic lvl, input int sel, input int bound, input string what, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (((sel == 0) ? restart_tx_rx : done) === lvl) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: level not seen within %0d cycles, wanted %0b", what, bound, lvl);
        end
    endtask

    // Full sequence. mode 0: cs per run as given; mode 1: run 0 status toggles
    // and never settles; mode 2: block lock drops while run 0 settles.
    task automatic run_seq(input string name, input int mode, input logic [4:0] v0, input logic [4:0] v1,
                           input int gt_dly, input int blk_dly, input int cs_dly, input bit poke_start);
        logic [4:0] vals[2];
        logic [4:0] codes[2];
        int         exp_pass_cnt;
        int         exp_fail_cnt;
        logic [4:0] exp_code;
        logic       exp_pass;
        int         n0;
        bit         ok;
        vals[0] = v0;
        vals[1] = v1;
        n0 = widths.size();
        rx_gt_locked_in = 1'b0;
        rx_block_lock_in = 1'b0;
        completion_status_in = 5'h1F;
        start = 1'b1;
        tick(4);
        start = 1'b0;
        tick(gt_dly - 4);
        rx_gt_locked_in = 1'b1;
        tick(10);
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL %s busy mid-run: got %0b want 1", name, busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL %s done mid-run: got %0b want 0", name, done); end
        if (poke_start) begin
            start = 1'b1;
            tick(3);
            start = 1'b0;
        end
        tick(blk_dly);
        rx_block_lock_in = 1'b1;
        tick(cs_dly);
        for (int r = 0; r < c_NUM_RUNS; r++) begin
            if (mode == 1 && r == 0) begin
                ok = 1'b0;
                for (int i = 0; i < 4000; i++) begin
                    completion_status_in = (((i / 2) % 2) == 0) ? 5'd1 : 5'd13;
                    tick(1);
                    if (restart_tx_rx === 1'b1) begin
                        ok = 1'b1;
                        break;
                    end
                end
                if (!ok) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s unstable-status timeout: no restart within 4000 cycles", name);
                end
            end else if (mode == 2 && r == 0) begin
                completion_status_in = vals[0];
                tick(30);
                rx_block_lock_in = 1'b0;
                completion_status_in = 5'h1F;
                tick(4);
                rx_block_lock_in = 1'b1;
            end else begin
                completion_status_in = vals[r];
            end
            if (r < c_NUM_RUNS - 1) begin
                wait_level(1'b1, 0, 3000, "restart rise", ok);
                completion_status_in = 5'h1F;
                wait_level(1'b0, 0, 100, "restart fall", ok);
                tick($urandom_range(20, 200));
            end
        end
        wait_level(1'b1, 1, 3000, "done rise", ok);
        tick(2);

        // Reference scoring from the per-run outcomes
        codes[0] = (mode == 1) ? 5'd18 : (mode == 2) ? 5'd19 : vals[0];
        codes[1] = vals[1];
        exp_pass_cnt = 0;
        exp_fail_cnt = 0;
        exp_code = 5'd0;
        for (int r = 0; r < c_NUM_RUNS; r++) begin
            if (codes[r] == 5'd1) exp_pass_cnt++;
            else begin
                exp_fail_cnt++;
                if (exp_code == 5'd0) exp_code = codes[r];
            end
        end
        exp_pass = (exp_fail_cnt == 0);

        n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL %s done: got %0b want 1", name, done); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL %s busy: got %0b want 0", name, busy); end
        n_checks++; if (pass !== exp_pass) begin n_errors++; $display("FAIL %s pass: got %0b want %0b", name, pass, exp_pass); end
        n_checks++; if (fail_code !== exp_code) begin n_errors++; $display("FAIL %s fail_code: got %0d want %0d", name, fail_code, exp_code); end
        n_checks++; if (pass_count !== 4'(exp_pass_cnt)) begin n_errors++; $display("FAIL %s pass_count: got %0d want %0d", name, pass_count, exp_pass_cnt); end
        n_checks++; if (fail_count !== 4'(exp_fail_cnt)) begin n_errors++; $display("FAIL %s fail_count: got %0d want %0d", name, fail_count, exp_fail_cnt); end
        n_checks++; if (run_index !== 4'(c_NUM_RUNS - 1)) begin n_errors++; $display("FAIL %s run_index: got %0d want %0d", name, run_index, c_NUM_RUNS - 1); end
        n_checks++; if (restart_tx_rx !== 1'b0) begin n_errors++; $display("FAIL %s restart idle: got %0b want 0", name, restart_tx_rx); end
        n_checks++; if (widths.size() - n0 != c_NUM_RUNS - 1) begin n_errors++; $display("FAIL %s restart pulses: got %0d want %0d", name, widths.size() - n0, c_NUM_RUNS - 1); end
        for (int k = n0; k < widths.size(); k++) begin
            n_checks++; if (widths[k] != c_RESTART) begin n_errors++; $display("FAIL %s restart width: got %0d want %0d", name, widths[k], c_RESTART); end
        end
    endtask

    task automatic test_reset();
        sys_reset = 1'b0;
        tick(3);
        n_checks++; if ({restart_tx_rx, busy, done, pass} !== 4'b0000) begin n_errors++; $display("FAIL reset flags: got %b want 0000", {restart_tx_rx, busy, done, pass}); end
        n_checks++; if ({fail_code, run_index, pass_count, fail_count} !== 17'd0) begin n_errors++; $display("FAIL reset fields: got %h want 0", {fail_code, run_index, pass_count, fail_count}); end
        sys_reset = 1'b1;
        tick(6);
        n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL reset idle: got %b want 00", {busy, done}); end
    endtask

    task automatic test_nominal();
        run_seq("nominal", 0, 5'd1, 5'd1, 50, 140, 800, 1'b0);
    endtask

    task automatic test_mixed_runs();
        run_seq("mixed", 0, 5'd12, 5'd1, 40, 100, 300, 1'b0);
    endtask

    task automatic test_gt_timeout();
        int  n0;
        int  cyc;
        bit  ok;
        n0 = widths.size();
        rx_gt_locked_in = 1'b0;
        rx_block_lock_in = 1'b0;
        completion_status_in = 5'h1F;
        start = 1'b1;
        cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick(1);
            cyc++;
            if (i == 3) start = 1'b0;
            if (i > 8 && done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL gt_timeout done: not seen in 600 cycles, wanted 1"); end
        n_checks++; if (cyc < 256 || cyc > 280) begin n_errors++; $display("FAIL gt_timeout latency: got %0d want 256..280", cyc); end
        n_checks++; if (fail_code !== 5'd16) begin n_errors++; $display("FAIL gt_timeout fail_code: got %0d want 16", fail_code); end
        n_checks++; if (pass !== 1'b0) begin n_errors++; $display("FAIL gt_timeout pass: got %0b want 0", pass); end
        n_checks++; if ({pass_count, fail_count, run_index} !== 12'd0) begin n_errors++; $display("FAIL gt_timeout counts: got %h want 0", {pass_count, fail_count, run_index}); end
        n_checks++; if (widths.size() != n0 || restart_tx_rx !== 1'b0) begin n_errors++; $display("FAIL gt_timeout restart: got %0d pulses want 0", widths.size() - n0); end
    endtask

    task automatic test_unstable_status();
        run_seq("unstable_cs", 1, 5'd1, 5'd1, 30, 60, 100, 1'b0);
    endtask

    task automatic test_lock_drop();
        run_seq("lock_drop", 2, 5'd1, 5'd1, 30, 60, 150, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] v0;
        logic [4:0] v1;
        for (int it = 0; it < 4; it++) begin
            v0 = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'($urandom_range(2, 30));
            v1 = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'($urandom_range(2, 30));
            run_seq("random", 0, v0, v1, $urandom_range(20, 80), $urandom_range(50, 200),
                    $urandom_range(100, 700), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_restart();
        bit ok;
        rx_gt_locked_in = 1'b0;
        rx_block_lock_in = 1'b0;
        completion_status_in = 5'h1F;
        start = 1'b1;
        tick(4);
        start = 1'b0;
        tick(30);
        rx_gt_locked_in = 1'b1;
        tick(30);
        rx_block_lock_in = 1'b1;
        tick(50);
        completion_status_in = 5'd12;
        wait_level(1'b1, 0, 3000, "mid-restart rise", ok);
        tick(3);
        n_checks++; if (restart_tx_rx !== 1'b1 || run_index !== 4'd1) begin n_errors++; $display("FAIL pre-reset restart/run_index: got %0b/%0d want 1/1", restart_tx_rx, run_index); end
        sys_reset = 1'b0;
        #1;
        n_checks++; if (restart_tx_rx !== 1'b0) begin n_errors++; $display("FAIL reset restart_tx_rx: got %0b want 0", restart_tx_rx); end
        n_checks++; if ({busy, done, pass} !== 3'b000) begin n_errors++; $display("FAIL reset busy/done/pass: got %b want 000", {busy, done, pass}); end
        n_checks++; if ({fail_code, run_index, pass_count, fail_count} !== 17'd0) begin n_errors++; $display("FAIL reset run fields: got %h want 0", {fail_code, run_index, pass_count, fail_count}); end
        tick(3);
        sys_reset = 1'b1;
        completion_status_in = 5'h1F;
        tick(8);
        n_checks++; if ({restart_tx_rx, busy, done} !== 3'b000) begin n_errors++; $display("FAIL post-reset idle: got %b want 000", {restart_tx_rx, busy, done}); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mixed_runs();
        test_gt_timeout();
        test_unstable_status();
        test_lock_drop();
        test_random();
        test_reset_mid_restart();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
